// File: rtl/sra_sequencer.sv
// sra_sequencer
// Moore control FSM that steps one operation through the datapath_SRA
// datapath. It drives every tri-state enable, register load enable and
// opcode line of the datapath.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; all enables off
// LOAD  | Input1/Input2 gated onto E/F, R1/R2 loaded
// EX1   | B2 driven from R1 or R2, AU1 computing (registered)
// FB    | AU1 result fed back into R1, iteration count decremented
// CAP   | R3 <= Sh3, R4 <= AU1, R5 <= Sh1 (B2 still driven)
// EX2   | B5 driven from R4 or R5, AU2 computing (registered)
// WB    | R3 <= AU2 (B5 still driven)
// FIN   | Done pulse, datapath drives Result
//
// Ports:
//   clk, rst_n        clock and synchronous active-low reset
//   start             begin an operation (sampled in IDLE only)
//   op, b2_sel,       operation controls, latched on the start edge
//   b5_sel, iter
//   In, Bus2,         tri-state / source enables toward the datapath
//   AU1_Bus3, AU1_Bus4,
//   Bus5, Bus7
//   LR                load enables for R1..R5 (bit 0 = R1)
//   Opcode            latched op ([1:0] AU1, [3:2] AU2)
//   Done              one-cycle result-valid pulse
//   busy              high outside IDLE
module sra_sequencer #(
  parameter int ITER_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        op,
  input  logic              b2_sel,
  input  logic              b5_sel,
  input  logic [ITER_W-1:0] iter,
  output logic              In,
  output logic [1:0]        Bus2,
  output logic              AU1_Bus3,
  output logic              AU1_Bus4,
  output logic [1:0]        Bus5,
  output logic [1:0]        Bus7,
  output logic [4:0]        LR,
  output logic [3:0]        Opcode,
  output logic              Done,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_EX1  = 3'd2,
    S_FB   = 3'd3,
    S_CAP  = 3'd4,
    S_EX2  = 3'd5,
    S_WB   = 3'd6,
    S_FIN  = 3'd7
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        op_q;
  logic              b2_q;
  logic              b5_q;
  logic [ITER_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      op_q  <= 4'h0;
      b2_q  <= 1'b0;
      b5_q  <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && start) begin
        op_q <= op;
        b2_q <= b2_sel;
        b5_q <= b5_sel;
        cnt  <= iter;
      end else if (state == S_FB) begin
        // FB is only entered with cnt != 0, so this never wraps
        cnt <= cnt - ITER_W'(1);
      end
    end
  end

  logic [1:0] bus2_sel;
  logic [1:0] bus5_sel;

  assign bus2_sel = b2_q ? 2'b10 : 2'b01;
  assign bus5_sel = b5_q ? 2'b10 : 2'b01;
  assign Opcode   = op_q;

  always_comb begin
    state_nxt = state;
    In        = 1'b0;
    Bus2      = 2'b00;
    AU1_Bus3  = 1'b0;
    AU1_Bus4  = 1'b0;
    Bus5      = 2'b00;
    Bus7      = 2'b00;
    LR        = 5'b00000;
    Done      = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        In        = 1'b1;
        LR        = 5'b00011;
        state_nxt = S_EX1;
      end
      S_EX1: begin
        Bus2      = bus2_sel;
        state_nxt = (cnt != '0) ? S_FB : S_CAP;
      end
      S_FB: begin
        // operand bus stays driven while AU1's registered result is captured
        Bus2      = bus2_sel;
        AU1_Bus3  = 1'b1;
        LR        = 5'b00001;
        state_nxt = S_EX1;
      end
      S_CAP: begin
        Bus2      = bus2_sel;
        Bus7      = 2'b01;
        LR        = 5'b11100;
        state_nxt = S_EX2;
      end
      S_EX2: begin
        Bus5      = bus5_sel;
        state_nxt = S_WB;
      end
      S_WB: begin
        Bus5      = bus5_sel;
        Bus7      = 2'b10;
        LR        = 5'b00100;
        state_nxt = S_FIN;
      end
      S_FIN: begin
        Done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
